// File: rtl/program_counter_ctx_pkg.sv
// rtl/program_counter_ctx_pkg.sv - shared Galetron fetch-stage types and default vectors
package galetron_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam int PC_RESET_VEC = 256;
    localparam int PC_CTX_VEC   = 1083;

    // Width of a return-stack occupancy count able to hold 0..depth inclusive
    function automatic int stack_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/program_counter_ctx_if.sv
// rtl/program_counter_ctx_if.sv - decoder/ALU control bundle and PC status outputs
interface program_counter_ctx_if
    import galetron_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int RAS_DEPTH = 4
);
    localparam int LVL_W = stack_level_w(RAS_DEPTH);

    logic [ADDR_W-1:0] address;
    logic              zero;
    logic              negative;
    logic              bzero;
    logic              bnegative;
    logic              jump;
    logic              call;
    logic              ret;
    logic              HLT;
    logic              jump_context_exchange;

    logic [ADDR_W-1:0] programCounter;
    logic              waiting;
    logic              halted;
    logic [LVL_W-1:0]  stack_level;
    logic              stack_overflow;
    logic              stack_underflow;

    // Decoder side: drives control, observes the fetch address and status
    modport master (
        output address, zero, negative, bzero, bnegative,
               jump, call, ret, HLT, jump_context_exchange,
        input  programCounter, waiting, halted, stack_level,
               stack_overflow, stack_underflow
    );

    // Program-counter unit side
    modport slave (
        input  address, zero, negative, bzero, bnegative,
               jump, call, ret, HLT, jump_context_exchange,
        output programCounter, waiting, halted, stack_level,
               stack_overflow, stack_underflow
    );

endinterface

// File: rtl/pc_return_stack.sv
// rtl/pc_return_stack.sv - hardware return-address stack for call/ret
module pc_return_stack
    import galetron_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             push,
    input  logic                             pop,
    input  logic [ADDR_W-1:0]                push_data,
    output logic [ADDR_W-1:0]                top,
    output logic [stack_level_w(RAS_DEPTH)-1:0] level,
    output logic                             full,
    output logic                             empty
);
    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam int LVL_W = stack_level_w(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_m1;
    logic              do_push;
    logic              do_pop;

    assign full     = (level_q == LVL_W'(RAS_DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign level_m1 = level_q - LVL_W'(1);
    assign top      = mem_q[level_m1[IDX_W-1:0]];
    // Guards keep the level in range even if a caller ignores full/empty
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty && !push;

    // Occupancy count; entries above the level are stale and never read
    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= '0;
        end else if (do_push) begin
            level_q <= level_q + LVL_W'(1);
        end else if (do_pop) begin
            level_q <= level_m1;
        end
    end

    // Entry storage; the slot at the current level is the next free one
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[level_q[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/program_counter_ctx.sv
// rtl/program_counter_ctx.sv - Galetron fetch PC sequencer with return stack and context wait
module program_counter_ctx
    import galetron_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int RESET_VEC = PC_RESET_VEC,
    parameter int CTX_VEC   = PC_CTX_VEC,
    parameter int CTX_WAIT  = 24414,
    parameter int RAS_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 resetCPU,
    program_counter_ctx_if.slave bus
);
    localparam int CNT_W = $clog2(CTX_WAIT + 1);
    localparam int LVL_W = stack_level_w(RAS_DEPTH);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CTX_WAIT - 1);
    localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] CTX_PC   = ADDR_W'(CTX_VEC);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              rs_push;
    logic              rs_pop;
    logic [ADDR_W-1:0] rs_top;
    logic [LVL_W-1:0]  rs_level;
    logic              rs_full;
    logic              rs_empty;

    logic [ADDR_W-1:0] pc_inc;
    logic              branch_sel;

    assign pc_inc     = pc_q + ADDR_W'(1);
    assign branch_sel = (bus.bzero & bus.zero) | (bus.bnegative & bus.negative);

    pc_return_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (resetCPU),
        .push      (rs_push),
        .pop       (rs_pop),
        .push_data (pc_inc),
        .top       (rs_top),
        .level     (rs_level),
        .full      (rs_full),
        .empty     (rs_empty)
    );

    // State, PC, settle counter and sticky flags; reset dominates all control
    always_ff @(posedge clock) begin
        if (resetCPU) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Next-state and next-PC selection; in RUN the first matching control wins
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        rs_push = 1'b0;
        rs_pop  = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.jump_context_exchange) begin
                    pc_d    = CTX_PC;
                    cnt_d   = '0;
                    state_d = WAIT;
                end else if (bus.HLT) begin
                    state_d = HALT;
                end else if (bus.ret) begin
                    if (!rs_empty) begin
                        pc_d   = rs_top;
                        rs_pop = 1'b1;
                    end else begin
                        pc_d  = pc_inc;
                        unf_d = 1'b1;
                    end
                end else if (bus.call) begin
                    pc_d = bus.address;
                    if (!rs_full) begin
                        rs_push = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (bus.jump) begin
                    pc_d = bus.address;
                end else if (branch_sel) begin
                    pc_d = pc_inc + bus.address;
                end else begin
                    pc_d = pc_inc;
                end
            end
            WAIT: begin
                // PC stays parked at the handler entry until the settle delay expires
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HALT: begin
                if (bus.jump_context_exchange) begin
                    pc_d    = CTX_PC;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.programCounter  = pc_q;
    assign bus.waiting         = (state_q == WAIT);
    assign bus.halted          = (state_q == HALT);
    assign bus.stack_level     = rs_level;
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;

endmodule
